// File: rtl/uart_rx_ctrl_pkg.sv
// ============================================================================
//  Module      : uart_rx_ctrl_pkg
//  Description : Shared UART receive constants: FSM state encoding and the
//                legal oversampling ratios.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_ctrl_pkg;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE    = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_START   = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DATA    = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_PARITY  = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_STOP    = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_ERR_CHK = 3'd5;

    localparam logic [5:0] c_PRESCALE_8  = 6'd8;
    localparam logic [5:0] c_PRESCALE_16 = 6'd16;
    localparam logic [5:0] c_PRESCALE_32 = 6'd32;

    // Bit index of the first and last data bit (start bit is index 0)
    localparam logic [3:0] c_FIRST_DATA_BIT = 4'd1;
    localparam logic [3:0] c_LAST_DATA_BIT  = 4'd8;

endpackage

`default_nettype wire

// File: rtl/uart_rx_ctrl_edge_bit_counter.sv
// ============================================================================
//  Module      : edge_bit_counter
//  Description : Oversample edge counter with bit counter; wraps the edge
//                index at prescale-1 and advances the bit index on each wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_bit_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    input  logic       load_first,
    input  logic [5:0] prescale,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       wrap
);

    logic [5:0] r_edge_cnt;
    logic [3:0] r_bit_cnt;
    logic       w_last_edge;

    // >= rather than == so an illegal ratio can never run the counter away
    assign w_last_edge = (r_edge_cnt >= (prescale - 6'd1));
    assign wrap        = enable & w_last_edge;

    always_ff @(posedge clk) begin
        if (rst || (clear && !load_first)) begin
            r_edge_cnt <= 6'd0;
            r_bit_cnt  <= 4'd0;
        end else if (load_first) begin
            // The detect cycle already counts as edge 0 of the start bit
            r_edge_cnt <= 6'd1;
            r_bit_cnt  <= 4'd0;
        end else if (enable) begin
            if (w_last_edge) begin
                r_edge_cnt <= 6'd0;
                r_bit_cnt  <= r_bit_cnt + 4'd1;
            end else begin
                r_edge_cnt <= r_edge_cnt + 6'd1;
            end
        end
    end

    assign edge_cnt = r_edge_cnt;
    assign bit_cnt  = r_bit_cnt;

endmodule

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// ============================================================================
//  Module      : uart_rx_ctrl
//  Description : UART receive control FSM; sequences start/data/parity/stop
//                sampling strobes and qualifies the received frame.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       par_en,
    input  logic [5:0] prescale,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stop_err,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stop_chk_en,
    output logic       deser_en,
    output logic       data_valid
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    logic [5:0]           r_prescale;
    logic                 r_par_en;

    logic w_bit_wrap;
    logic w_in_frame;
    logic w_first_data;
    logic w_abort;
    logic w_cnt_load;
    logic w_cnt_clear;

    assign w_in_frame = (r_state == c_ST_START) || (r_state == c_ST_DATA) ||
                        (r_state == c_ST_PARITY) || (r_state == c_ST_STOP);

    // The start checker reports on the first cycle of the first data bit
    assign w_first_data = (r_state == c_ST_DATA) && (bit_cnt == c_FIRST_DATA_BIT) &&
                          (edge_cnt == 6'd0);
    assign w_abort      = w_first_data && strt_glitch;

    assign w_cnt_load  = (w_next_state == c_ST_START) &&
                         ((r_state == c_ST_IDLE) || (r_state == c_ST_ERR_CHK));
    assign w_cnt_clear = (w_next_state == c_ST_IDLE) || (w_next_state == c_ST_ERR_CHK);

    edge_bit_counter u_edge_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .enable     (w_in_frame),
        .clear      (w_cnt_clear),
        .load_first (w_cnt_load),
        .prescale   (r_prescale),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .wrap       (w_bit_wrap)
    );

    // Frame configuration is captured only while idle and held for the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale <= c_PRESCALE_8;
            r_par_en   <= 1'b0;
        end else if (r_state == c_ST_IDLE) begin
            r_prescale <= prescale;
            r_par_en   <= par_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!rx_in) begin
                    w_next_state = c_ST_START;
                end
            end
            c_ST_START: begin
                if (w_bit_wrap) begin
                    w_next_state = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_abort) begin
                    w_next_state = c_ST_IDLE;
                end else if (w_bit_wrap && (bit_cnt >= c_LAST_DATA_BIT)) begin
                    w_next_state = r_par_en ? c_ST_PARITY : c_ST_STOP;
                end
            end
            c_ST_PARITY: begin
                if (w_bit_wrap) begin
                    w_next_state = c_ST_STOP;
                end
            end
            c_ST_STOP: begin
                if (w_bit_wrap) begin
                    w_next_state = c_ST_ERR_CHK;
                end
            end
            c_ST_ERR_CHK: begin
                w_next_state = rx_in ? c_ST_IDLE : c_ST_START;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        dat_samp_en = w_in_frame;
        strt_chk_en = (r_state == c_ST_START)  && w_bit_wrap;
        deser_en    = (r_state == c_ST_DATA)   && w_bit_wrap && !w_abort;
        par_chk_en  = (r_state == c_ST_PARITY) && w_bit_wrap;
        stop_chk_en = (r_state == c_ST_STOP)   && w_bit_wrap;
        data_valid  = (r_state == c_ST_ERR_CHK) && !stop_err && !(r_par_en && par_err);
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
//  Module      : tb_uart_rx_ctrl
//  Description : Self-checking bench for uart_rx_ctrl driven by a table of
//                frame records plus hand-written reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic       par_en;
    logic [5:0] prescale;
    logic       strt_glitch;
    logic       par_err;
    logic       stop_err;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stop_chk_en;
    logic       deser_en;
    logic       data_valid;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         presc;
        logic       par_en;
        logic [7:0] data;
        logic       par_err;
        logic       stop_err;
        logic       glitch;
        logic       b2b;
        int         presc_mid;
        int         exp_valid;
        int         exp_vcyc;
        int         exp_deser;
        int         exp_strt;
        int         exp_par;
        int         exp_stop;
        int         exp_err;
    } vec_t;

    localparam int c_NVEC = 9;
    vec_t vecs[c_NVEC];

    uart_rx_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .par_en      (par_en),
        .prescale    (prescale),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stop_err    (stop_err),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .dat_samp_en (dat_samp_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stop_chk_en (stop_chk_en),
        .deser_en    (deser_en),
        .data_valid  (data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Serial line level at cycle k of the frame (cycle 0 = detect cycle)
    function automatic logic rx_bit(input vec_t v, input int k, input int len);
        int pos;
        int b;
        if (v.glitch) return (k == 0) ? 1'b0 : 1'b1;
        if (k < len) pos = k;
        else if (v.b2b && k < 2 * len) pos = k - len;
        else return 1'b1;
        b = pos / v.presc;
        if (b == 0) return 1'b0;
        if (b <= 8) return v.data[b-1];
        if (b == 9 && v.par_en) return ^v.data;
        return 1'b1;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, " edge_cnt"}, int'(edge_cnt), 0);
        check({tag, " bit_cnt"}, int'(bit_cnt), 0);
        check({tag, " dat_samp_en"}, int'(dat_samp_en), 0);
        check({tag, " strobes"},
              int'({strt_chk_en, par_chk_en, stop_chk_en, deser_en, data_valid}), 0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   len, kmax;
        int   n_valid, vcyc, n_deser, n_strt, n_par, n_stop, err_cyc;
        logic prev_strt;
        string tag;
        tag       = $sformatf("v%0d", idx);
        len       = (v.par_en ? 11 : 10) * v.presc;
        kmax      = (v.b2b ? 2 * len : len) + 4;
        n_valid   = 0;
        vcyc      = -1;
        n_deser   = 0;
        n_strt    = 0;
        n_par     = 0;
        n_stop    = 0;
        err_cyc   = -1;
        prev_strt = 1'b0;
        for (int k = 0; k < kmax; k++) begin
            @(negedge clk);
            rx_in = rx_bit(v, k, len);
            if (k == 0) begin
                prescale = v.presc[5:0];
                par_en   = v.par_en;
            end
            if (v.presc_mid != 0 && k == 3 * v.presc) prescale = v.presc_mid[5:0];
            par_err     = v.par_err;
            stop_err    = (k <= len) ? v.stop_err : 1'b0;
            strt_glitch = prev_strt & v.glitch;
            #1;
            prev_strt = strt_chk_en;
            if (data_valid)  begin n_valid++; vcyc = k; end
            if (deser_en)    n_deser++;
            if (strt_chk_en) n_strt++;
            if (par_chk_en)  n_par++;
            if (stop_chk_en) begin n_stop++; err_cyc = k + 1; end
            if (k == 1) begin
                check({tag, " k1 edge_cnt"}, int'(edge_cnt), 1);
                check({tag, " k1 bit_cnt"}, int'(bit_cnt), 0);
                check({tag, " k1 dat_samp_en"}, int'(dat_samp_en), 1);
            end
            if (!v.glitch && k == 5 * v.presc + 3) begin
                check({tag, " mid edge_cnt"}, int'(edge_cnt), 3);
                check({tag, " mid bit_cnt"}, int'(bit_cnt), 5);
            end
            if (v.glitch && k == v.presc + 1) check_quiet({tag, " abort"});
        end
        check({tag, " data_valid count"}, n_valid, v.exp_valid);
        check({tag, " data_valid cycle"}, vcyc, v.exp_vcyc);
        check({tag, " deser_en count"}, n_deser, v.exp_deser);
        check({tag, " strt_chk_en count"}, n_strt, v.exp_strt);
        check({tag, " par_chk_en count"}, n_par, v.exp_par);
        check({tag, " stop_chk_en count"}, n_stop, v.exp_stop);
        check({tag, " err_chk cycle"}, err_cyc, v.exp_err);
        check_quiet({tag, " end idle"});
        @(negedge clk);
        strt_glitch = 1'b0;
        stop_err    = 1'b0;
        par_err     = 1'b0;
        rx_in       = 1'b1;
    endtask

    initial begin
        //           P   par   data   perr  serr  glit  b2b   mid valid vcyc deser strt par stop err
        vecs[0] = '{ 8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 0,  1,  80,   8,  1,  0,  1,  80};
        vecs[1] = '{16, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 0,  0,  -1,   8,  1,  1,  1, 176};
        vecs[2] = '{ 8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 0,  0,  -1,   0,  1,  0,  0,  -1};
        vecs[3] = '{ 8, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 0,  1, 160,  16,  2,  0,  2, 160};
        vecs[4] = '{ 8, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1,  80,   8,  1,  0,  1,  80};
        vecs[5] = '{16, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 0,  1, 160,   8,  1,  0,  1, 160};
        vecs[6] = '{32, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 0,  1, 352,   8,  1,  1,  1, 352};
        vecs[7] = '{16, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 0,  1, 160,   8,  1,  0,  1, 160};
        vecs[8] = '{ 8, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0,  0,  -1,   8,  1,  1,  1,  88};

        rst         = 1'b1;
        rx_in       = 1'b0;
        par_en      = 1'b0;
        prescale    = 6'd8;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stop_err    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        // Line held low through reset must not have started a frame
        check_quiet("reset");
        @(negedge clk);
        rst   = 1'b0;
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_quiet("post reset idle");

        for (int i = 0; i < c_NVEC; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of data bit 4
        for (int k = 0; k <= 4 * 8 + 2; k++) begin
            @(negedge clk);
            prescale = 6'd8;
            par_en   = 1'b0;
            rx_in    = rx_bit(vecs[0], k, 80);
            if (k == 4 * 8 + 2) rst = 1'b1;
        end
        @(negedge clk);
        rst   = 1'b0;
        rx_in = 1'b1;
        #1;
        check_quiet("mid-frame reset");
        repeat (3) @(negedge clk);
        #1;
        check_quiet("after reset idle");
        run_vec(99, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
